// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output collector.
//   FIR_WIDTH   : default sample width (matches the filter dataout width)
//   fir_state_e : collector control states
//   fir_decim_e : decim_sel encoding (00=1, 01=2, 10=4, 11=8)
//   decim_max() : terminal count of the decimation counter for a given encoding
package fir_pkg;
  localparam int FIR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } fir_state_e;

  typedef enum logic [1:0] {
    DEC_1 = 2'b00,
    DEC_2 = 2'b01,
    DEC_4 = 2'b10,
    DEC_8 = 2'b11
  } fir_decim_e;

  // Counter runs 0..N-1, so the terminal value is N-1.
  function automatic logic [2:0] decim_max(input fir_decim_e sel);
    case (sel)
      DEC_1:   return 3'd0;
      DEC_2:   return 3'd1;
      DEC_4:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction
endpackage

// File: rtl/fir_fifo.sv
// First-word-fall-through sample FIFO.
//   clk, rst_n : clock, async active-low reset (pointers/level cleared at once)
//   push, din  : write request and data (ignored when full unless a pop coincides)
//   pop        : read request (ignored when empty)
//   dout       : head sample, forced to 0 while empty
//   full/empty : occupancy flags
//   level      : occupancy, 0..DEPTH
module fir_fifo
  import fir_pkg::*;
#(
  parameter  int WIDTH = FIR_WIDTH,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]               level_q;
  logic                        push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push_ok = push && (!full || pop_ok);

  // Storage is not reset; dout masking keeps the visible head at 0 when empty.
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= din;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;
endmodule

// File: rtl/fir_out_collector.sv
// Captures decimated FIR output samples into a FWFT FIFO.
//   clk, rst_n       : clock, async active-low reset
//   start, stop      : one-cycle run control (stop wins; start ignored while busy)
//   decim_sel        : decimation 1/2/4/8, latched on accepted start
//   din              : filter output, one sample per clk
//   out_data/valid   : FIFO head and not-empty
//   out_ready        : consumer pop strobe (effective with out_valid)
//   busy             : not IDLE
//   overflow         : sticky, set when a capture is dropped; cleared on start
//   level            : FIFO occupancy
module fir_out_collector
  import fir_pkg::*;
#(
  parameter  int WIDTH   = FIR_WIDTH,
  parameter  int DEPTH   = 8,
  parameter  int DISCARD = 4,
  localparam int LW      = $clog2(DEPTH) + 1,
  localparam int FW      = (DISCARD > 1) ? $clog2(DISCARD) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       decim_sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic [LW-1:0]    level
);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(DISCARD - 1);

  fir_state_e    state_q, state_d;
  fir_decim_e    dsel_q, dsel_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [2:0]    dec_q, dec_d;
  logic          ovf_q, ovf_d;
  logic          go, capture, pop, full, empty, push;

  assign go = (state_q == ST_IDLE) && start && !stop;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go) state_d = ST_FLUSH;
      ST_FLUSH: if (stop) state_d = ST_IDLE;
                else if (flush_q == FLUSH_LAST) state_d = ST_RUN;
      ST_RUN:   if (stop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // outputs: capture on the first RUN cycle (counter cleared) and every N-th after
  always_comb begin
    busy    = (state_q != ST_IDLE);
    capture = (state_q == ST_RUN) && !stop && (dec_q == 3'd0);
  end

  // run counters and sticky overflow
  always_comb begin
    dsel_d  = dsel_q;
    flush_d = flush_q;
    dec_d   = dec_q;
    ovf_d   = ovf_q;
    if (go) begin
      dsel_d  = fir_decim_e'(decim_sel);
      flush_d = '0;
      dec_d   = '0;
      ovf_d   = 1'b0;
    end
    if (state_q == ST_FLUSH && flush_q != FLUSH_LAST) flush_d = flush_q + FW'(1);
    if (state_q == ST_RUN) dec_d = (dec_q == decim_max(dsel_q)) ? 3'd0 : dec_q + 3'd1;
    if (capture && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsel_q  <= DEC_1;
      flush_q <= '0;
      dec_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      dsel_q  <= dsel_d;
      flush_q <= flush_d;
      dec_q   <= dec_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pop       = out_valid && out_ready;
  assign push      = capture && (!full || pop);
  assign out_valid = !empty;
  assign overflow  = ovf_q;

  fir_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_fir_out_collector.sv
module tb_fir_out_collector;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, stop, out_ready;
  logic [1:0]       decim_sel;
  logic [WIDTH-1:0] din, out_data;
  logic             out_valid, busy, overflow;
  logic [LW-1:0]    level;

  int n_chk = 0;
  int n_err = 0;

  fir_out_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DISCARD(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .decim_sel(decim_sel),
    .din(din), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One edge; returns at the following falling edge, where outputs are sampled
  // and inputs are changed.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start a run; returns in the first RUN cycle with din=4 applied.
  task automatic start_run(input logic [1:0] sel);
    decim_sel = sel;
    start = 1'b1;
    cyc();
    start = 1'b0;
    din = '0;
    chk("flush_busy", busy, 1);
    repeat (4) begin
      chk("flush_novalid", out_valid, 0);
      cyc();
      din = din + 1'b1;
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    decim_sel = 2'b00; din = '0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;

    // decimation 1, streaming consumer
    out_ready = 1'b1;
    start_run(2'b00);
    for (int j = 0; j < 6; j++) begin
      cyc();
      chk("d1_valid", out_valid, 1);
      chk("d1_data", out_data, 4 + j);
      chk("d1_level", level, 1);
      din = din + 1'b1;
    end
    chk("d1_ovf", overflow, 0);
    do_stop();
    chk("d1_stop_busy", busy, 0);
    chk("d1_stop_empty", out_valid, 0);

    // decimation 4
    start_run(2'b10);
    k = 0;
    for (int c = 0; c < 13; c++) begin
      cyc();
      if (out_valid) begin
        chk("d4_data", out_data, 4 + 4 * k);
        k++;
      end
      din = din + 1'b1;
    end
    chk("d4_count", k, 4);
    do_stop();

    // overflow: 12 captures, no consumer
    out_ready = 1'b0;
    start_run(2'b00);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("ovf_level", level, (i < 8) ? i : 8);
      chk("ovf_flag", overflow, (i >= 9) ? 1 : 0);
      din = din + 1'b1;
    end
    do_stop();
    chk("ovf_sticky", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", out_data, 4 + i);
      cyc();
    end
    chk("ovf_drained", out_valid, 0);

    // full FIFO with simultaneous pop and capture
    out_ready = 1'b0;
    start_run(2'b00);
    chk("full_ovf_clr", overflow, 0);
    repeat (8) begin
      cyc();
      din = din + 1'b1;
    end
    chk("full_level", level, 8);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("full_pp_level", level, 8);
      chk("full_pp_ovf", overflow, 0);
      chk("full_pp_data", out_data, 4 + i);
      din = din + 1'b1;
    end
    do_stop();
    chk("full_stop_level", level, 7);
    for (int i = 0; i < 7; i++) begin
      chk("full_drain", out_data, 9 + i);
      cyc();
    end
    chk("full_drained", out_valid, 0);

    // stop after 3 captures; start while busy is ignored
    out_ready = 1'b0;
    start_run(2'b00);
    cyc(); din = din + 1'b1;
    start = 1'b1; decim_sel = 2'b11;
    cyc(); din = din + 1'b1;
    start = 1'b0;
    cyc(); din = din + 1'b1;
    chk("s3_level", level, 3);
    do_stop();
    chk("s3_busy", busy, 0);
    chk("s3_level_stop", level, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("s3_drain", out_data, 4 + i);
      cyc();
    end
    chk("s3_drained", out_valid, 0);

    // simultaneous start and stop in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);

    // asynchronous reset with level 5
    out_ready = 1'b0;
    start_run(2'b00);
    repeat (5) begin
      cyc();
      din = din + 1'b1;
    end
    chk("ar_level_pre", level, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_level", level, 0);
    chk("ar_busy", busy, 0);
    chk("ar_data", out_data, 0);
    @(negedge clk);
    // release and start on the very first edge with rst_n high
    rst_n = 1'b1;
    start = 1'b1; decim_sel = 2'b00;
    cyc();
    start = 1'b0;
    chk("ar_start_busy", busy, 1);
    do_stop();
    chk("ar_stop_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fir_out_collector.md
FIR_OUT_COLLECTOR -- requirements
Module: fir_out_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the sample width, equal to the filter dataout width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the FIFO entries (power of two, at least 2).
REQ-003 SHALL have parameter DISCARD, default 4, meaning the filter pipeline fill samples dropped after start (at least 1).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to begin a capture run.
REQ-007 SHALL have port stop, input, 1 bit: one-cycle request to end a capture run.
REQ-008 SHALL have port decim_sel, input, 2 bits: decimation 00=1, 01=2, 10=4, 11=8; sampled on accepted start.
REQ-009 SHALL have port din, input, WIDTH bits: filter output sample, one new sample per clk.
REQ-010 SHALL have port out_data, output, WIDTH bits: FIFO head sample.
REQ-011 SHALL have port out_valid, output, 1 bit: FIFO not empty.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts out_data when out_valid is also high.
REQ-013 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag set when a capture is dropped because the FIFO is full.
REQ-015 SHALL have port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 SHALL implement states IDLE, FLUSH and RUN.
REQ-017 In IDLE, start SHALL move the block to FLUSH, latch decim_sel, clear the flush and decimation counters, and clear overflow.
REQ-018 In FLUSH, the block SHALL drop DISCARD consecutive din samples, counting the start+1 cycle as the first, then enter RUN.
REQ-019 In RUN, the block SHALL capture din on the first RUN cycle and then every N-th cycle, where N is the latched decimation factor; the decimation counter SHALL wrap N-1 to 0.
REQ-020 stop in FLUSH or RUN SHALL return the block to IDLE on the next edge; no capture occurs in the cycle stop is high.
REQ-021 Simultaneous start and stop SHALL make stop win; start while busy is high SHALL be ignored.
REQ-022 FIFO contents SHALL be retained across stop and drain normally while in IDLE.
REQ-023 The FIFO SHALL be first-word-fall-through: out_data is valid in the same cycle out_valid is high, and a pop occurs when out_valid and out_ready are both high.
REQ-024 A capture when level==DEPTH with no pop SHALL be dropped and SHALL set overflow.
REQ-025 A capture when level==DEPTH with a simultaneous pop SHALL be accepted; level stays DEPTH and overflow is not set.
REQ-026 A simultaneous push and pop at level==0 SHALL not occur: the pop is not valid, so level goes to 1.
REQ-027 The capture-to-out_valid latency SHALL be 1 clk: a sample captured at edge k is visible after edge k.
REQ-028 Samples SHALL pass through unmodified at WIDTH bits; no arithmetic is applied to data.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 When rst_n is low, state SHALL be IDLE, all counters and pointers 0, level=0, out_valid=0, busy=0, overflow=0, and out_data=0.
REQ-031 Reset assertion mid-run SHALL discard all FIFO contents immediately, without waiting for clk.
REQ-032 Reset release SHALL require no extra start-up cycles; start is honoured on the first edge with rst_n high.

Structure
REQ-033 Shared package fir_pkg SHALL hold the WIDTH default, the state enumeration and the decim_sel encoding.
REQ-034 The FIFO SHALL be a single sub-module, fir_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, level); all control logic remains in fir_out_collector.

Verification
REQ-035 Reset, start, decim_sel=00, din=0,1,2,... from the start+1 cycle, out_ready=1: the first out_data is 4, then 5, 6, ..., and overflow stays 0.
REQ-036 decim_sel=10, din as in REQ-035, out_ready=1: out_data is 4, 8, 12, 16.
REQ-037 decim_sel=00, out_ready=0 for 12 RUN cycles: level saturates at 8, out_data reads 4..11, and overflow=1 from the ninth capture onward.
REQ-038 FIFO full with out_ready=1 and a capture in the same cycle: level stays 8, overflow=0, and the order is preserved.
REQ-039 stop after 3 captures, then out_ready=1: busy=0 on the next edge and exactly 3 samples drain; a start issued while busy is high has no effect.
REQ-040 rst_n pulled low asynchronously with level=5: out_valid=0 and level=0 before the next clk edge.
